// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg
//   Shared constants for the video RAM arbiter: default bus widths, the
//   default depth of the posted-write buffer and the CPU FSM state encodings.
//   Imported by every file of the arbiter.
package vram_arbiter_pkg;

    localparam int AW_DEF         = 16;
    localparam int DW_DEF         = 16;
    localparam int WBUF_DEPTH_DEF = 4;

    // CPU port FSM encodings; kept as fixed 2-bit constants so the debug
    // output decodes the same way in every build.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

endpackage

// File: rtl/vram_arbiter_wbuf.sv
// vram_arbiter_wbuf
//   Posted-write FIFO for the video RAM arbiter. Circular buffer with
//   wrap-around pointers and an occupancy count one bit wider than the
//   pointers so that "full" and "empty" are distinct.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset (empties the buffer)
//   push   in   write din at the tail; ignored while full
//   pop    in   drop the head entry; ignored while empty
//   din    in   W-bit entry to push
//   dout   out  head entry (valid while !empty)
//   empty  out  no entries stored
//   full   out  DEPTH entries stored
module vram_arbiter_wbuf
    import vram_arbiter_pkg::*;
#(
    parameter int W     = AW_DEF + DW_DEF,
    parameter int DEPTH = WBUF_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap-around.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Owns the single-port synchronous video RAM and shares it between the GPU
//   fetch path (never stalled, fixed 1-cycle latency) and a CPU port. CPU
//   writes are posted through vram_arbiter_wbuf; CPU reads wait until no GPU
//   fetch is using the RAM and the write buffer has drained.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   gpuAddr/gpuRE     GPU fetch address and request (this cycle)
//   gpuData           GPU fetch data (the cycle after gpuRE, then held)
//   cpuReq/cpuWE      CPU request level and direction (1 = write)
//   cpuAddr/cpuWData  CPU address and write data
//   cpuAck/cpuRData   one-cycle completion pulse and read data
//   ramAddr/ramWData/ramWE/ramRData   RAM interface (read data 1 cycle late)
//   wbufFull          write buffer full
//   cpuStallCnt       saturating count of cpuReq cycles not in ACK
//   dbgState          CPU FSM state (debug)
//
// CPU handshake: the CPU raises cpuReq with cpuWE/cpuAddr/cpuWData stable and
// holds all of them until it sees cpuAck high for one cycle; the request is
// sampled only in IDLE, so one request yields exactly one ack. cpuRData is
// valid in the ack cycle of a read and holds afterwards.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] gpuAddr,
    input  logic          gpuRE,
    output logic [DW-1:0] gpuData,
    input  logic          cpuReq,
    input  logic          cpuWE,
    input  logic [AW-1:0] cpuAddr,
    input  logic [DW-1:0] cpuWData,
    output logic          cpuAck,
    output logic [DW-1:0] cpuRData,
    output logic [AW-1:0] ramAddr,
    output logic [DW-1:0] ramWData,
    output logic          ramWE,
    input  logic [DW-1:0] ramRData,
    output logic          wbufFull,
    output logic [15:0]   cpuStallCnt,
    output logic [1:0]    dbgState
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             wbuf_push;
    logic             wbuf_empty;
    logic [AW+DW-1:0] wbuf_head;
    logic             gpu_go;
    logic             slot_drain;
    logic             slot_rd;
    logic [AW-1:0]    ram_addr_q;
    logic             gpu_rd_q;
    logic [DW-1:0]    gpu_hold;

    vram_arbiter_wbuf #(
        .W     (AW + DW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (wbuf_push),
        .pop   (slot_drain),
        .din   ({cpuAddr, cpuWData}),
        .dout  (wbuf_head),
        .empty (wbuf_empty),
        .full  (wbufFull)
    );

    // Slot priority: GPU fetch, then write drain, then CPU read issue.
    // gpuRE is masked during reset so the RAM bus reads as all zero.
    assign gpu_go     = gpuRE && rst;
    assign slot_drain = !gpu_go && !wbuf_empty;
    assign slot_rd    = !gpu_go && wbuf_empty && (state == ST_RD_WAIT);

    // The address holds its last value in idle slots.
    always_comb begin
        ramAddr = ram_addr_q;
        if (gpu_go)          ramAddr = gpuAddr;
        else if (slot_drain) ramAddr = wbuf_head[AW+DW-1:DW];
        else if (slot_rd)    ramAddr = cpuAddr;
    end

    assign ramWE    = slot_drain;
    assign ramWData = slot_drain ? wbuf_head[DW-1:0] : '0;

    // GPU data bypasses straight from the RAM the cycle after a fetch and is
    // otherwise served from the hold register.
    assign gpuData  = gpu_rd_q ? ramRData : gpu_hold;
    assign cpuAck   = (state == ST_ACK);
    assign dbgState = state;

    always_comb begin
        state_nxt = state;
        wbuf_push = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpuReq) begin
                    if (!cpuWE) begin
                        state_nxt = ST_RD_WAIT;
                    end else if (!wbufFull) begin
                        wbuf_push = 1'b1;
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_RD_WAIT: if (slot_rd) state_nxt = ST_RD_DATA;
            ST_RD_DATA: state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cpuRData    <= '0;
            cpuStallCnt <= '0;
            ram_addr_q  <= '0;
            gpu_rd_q    <= 1'b0;
            gpu_hold    <= '0;
        end else begin
            state      <= state_nxt;
            ram_addr_q <= ramAddr;
            gpu_rd_q   <= gpuRE;
            if (gpu_rd_q)
                gpu_hold <= ramRData;
            if (state == ST_RD_DATA)
                cpuRData <= ramRData;
            if (cpuReq && (state != ST_ACK) && (cpuStallCnt != 16'hFFFF))
                cpuStallCnt <= cpuStallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter. Holds a behavioural RAM, a
//   reference memory image plus a queue of posted writes, and per-cycle
//   expectations derived from the slot priority rules.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] gpuAddr;
    logic        gpuRE;
    logic [15:0] gpuData;
    logic        cpuReq;
    logic        cpuWE;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWData;
    logic        cpuAck;
    logic [15:0] cpuRData;
    logic [15:0] ramAddr;
    logic [15:0] ramWData;
    logic        ramWE;
    logic [15:0] ramRData;
    logic        wbufFull;
    logic [15:0] cpuStallCnt;
    logic [1:0]  dbgState;

    vram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .gpuAddr     (gpuAddr),
        .gpuRE       (gpuRE),
        .gpuData     (gpuData),
        .cpuReq      (cpuReq),
        .cpuWE       (cpuWE),
        .cpuAddr     (cpuAddr),
        .cpuWData    (cpuWData),
        .cpuAck      (cpuAck),
        .cpuRData    (cpuRData),
        .ramAddr     (ramAddr),
        .ramWData    (ramWData),
        .ramWE       (ramWE),
        .ramRData    (ramRData),
        .wbufFull    (wbufFull),
        .cpuStallCnt (cpuStallCnt),
        .dbgState    (dbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (ramWE) mem[ramAddr] <= ramWData;
        ramRData <= mem[ramAddr];
    end

    // ---------------- reference model state ----------------
    logic [15:0] ref_mem [0:65535];
    logic [31:0] exp_q[$];          // posted writes {addr, data} not yet in RAM
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          txn      = 0;      // 0 none, 1 write waiting, 2 read waiting, 3 ack due
    logic        txn_rd   = 1'b0;
    int          req_cyc  = 0;
    int          ack_cyc  = -1;
    logic [15:0] exp_rdata = '0;
    logic [15:0] m_stall  = '0;
    logic        g_prev_valid = 1'b0;
    logic [15:0] g_prev_val = '0;
    logic [15:0] g_hold   = '0;
    logic [15:0] last_addr = '0;
    int          gpu_burst = 0;
    logic        gpu_rand  = 1'b0;
    logic [15:0] gpu_base  = '0;

    function automatic logic [15:0] init_val(input int i);
        return i[15:0] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle of expectations, evaluated mid-cycle with inputs stable.
    task automatic check_cycle();
        int   sz;
        logic exp_ack;
        logic rd_go;
        logic [31:0] head;
        sz = exp_q.size();

        chk("gpu_data", gpuData, g_prev_valid ? g_prev_val : g_hold);
        if (g_prev_valid) g_hold = g_prev_val;

        exp_ack = (txn == 3) && (cyc == ack_cyc);
        chk("cpu_ack", cpuAck, exp_ack);
        if (exp_ack && txn_rd) chk("cpu_rdata", cpuRData, exp_rdata);

        chk("stall_cnt", cpuStallCnt, m_stall);
        if (cpuReq && !exp_ack && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;

        chk("wbuf_full", wbufFull, sz == 4);

        rd_go = !gpuRE && sz == 0 && txn == 2 && cyc > req_cyc;
        if (gpuRE) begin
            chk("gpu_ram_we", ramWE, 0);
            chk("gpu_ram_addr", ramAddr, gpuAddr);
            g_prev_val = ref_mem[gpuAddr];
            last_addr  = gpuAddr;
        end else if (sz > 0) begin
            head = exp_q[0];
            chk("drain_we", ramWE, 1);
            chk("drain_addr", ramAddr, head[31:16]);
            chk("drain_data", ramWData, head[15:0]);
            ref_mem[head[31:16]] = head[15:0];
            last_addr = head[31:16];
            void'(exp_q.pop_front());
        end else if (rd_go) begin
            chk("rd_issue_we", ramWE, 0);
            chk("rd_issue_addr", ramAddr, cpuAddr);
            exp_rdata = ref_mem[cpuAddr];
            last_addr = cpuAddr;
            txn = 3;
            ack_cyc = cyc + 2;
        end else begin
            chk("idle_we", ramWE, 0);
            chk("idle_addr", ramAddr, last_addr);
        end
        g_prev_valid = gpuRE;

        if (txn == 1 && sz < 4) begin
            exp_q.push_back({cpuAddr, cpuWData});
            txn = 3;
            ack_cyc = cyc + 1;
        end
        if (exp_ack) txn = 0;
    endtask

    // Drive GPU inputs for this cycle, check mid-cycle, then advance.
    task automatic tick();
        if (gpu_burst > 0) begin
            gpuRE = 1'b1;
            gpuAddr = gpu_base;
            gpu_burst--;
        end else if (gpu_rand) begin
            gpuRE = ($urandom_range(0, 9) < 6);
            gpuAddr = 16'h0300 + 16'($urandom_range(0, 15));
        end else begin
            gpuRE = 1'b0;
        end
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d);
        cpuReq = 1'b1;
        cpuWE = we;
        cpuAddr = a;
        cpuWData = d;
        txn = we ? 1 : 2;
        txn_rd = !we;
        req_cyc = cyc;
        for (int i = 0; i < 300 && txn != 0; i++) tick();
        chk("cpu_done", txn, 0);
        txn = 0;
        cpuReq = 1'b0;
        cpuWE = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          c0;
        logic [15:0] st0;
        rst = 1'b0;
        gpuRE = 1'b0;
        gpuAddr = '0;
        cpuReq = 1'b0;
        cpuWE = 1'b0;
        cpuAddr = '0;
        cpuWData = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] <= init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem[16'h0040] <= 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;

        // Reset state
        #2;
        chk("rst_ack", cpuAck, 0);
        chk("rst_rdata", cpuRData, 0);
        chk("rst_gpu_data", gpuData, 0);
        chk("rst_stall", cpuStallCnt, 0);
        chk("rst_ram_we", ramWE, 0);
        chk("rst_ram_addr", ramAddr, 0);
        chk("rst_ram_wdata", ramWData, 0);
        chk("rst_full", wbufFull, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // GPU fetch latency and hold
        gpu_base = 16'h0040;
        gpu_burst = 1;
        tick();
        chk("gpu_beef", gpuData, 16'hBEEF);
        idle(2);
        chk("gpu_hold_beef", gpuData, 16'hBEEF);

        // Posted write under a 5-cycle GPU burst on the same address
        gpu_base = 16'h0100;
        gpu_burst = 5;
        c0 = cyc;
        cpu_op(1'b1, 16'h0100, 16'h1234);
        chk("wr_ack_latency", cyc - c0, 2);
        idle(6);
        chk("wr_landed", mem[16'h0100], 16'h1234);

        // Five writes against a saturating GPU: buffer fills, fifth waits
        gpu_base = 16'h0111;
        gpu_burst = 20;
        for (int k = 0; k < 4; k++) cpu_op(1'b1, 16'h0110 + 16'(k), 16'hC000 + 16'(k));
        chk("wbuf_full_4", wbufFull, 1);
        c0 = cyc;
        cpu_op(1'b1, 16'h0114, 16'hC004);
        chk("fifth_waited", (cyc - c0) > 2, 1);
        idle(8);
        for (int k = 0; k < 5; k++) chk("burst_landed", mem[16'h0110 + 16'(k)], 16'hC000 + 16'(k));

        // Read after write sees the new data
        cpu_op(1'b1, 16'h0200, 16'h00AA);
        cpu_op(1'b0, 16'h0200, 16'h0000);
        chk("raw_data", cpuRData, 16'h00AA);

        // Read blocked by a 10-cycle GPU burst
        st0 = m_stall;
        gpu_base = 16'h0040;
        gpu_burst = 10;
        cpu_op(1'b0, 16'h0100, 16'h0000);
        chk("stall_read", cpuStallCnt, st0 + 16'd12);
        chk("blocked_rdata", cpuRData, 16'h1234);
        idle(2);

        // Reset with two buffered writes and a read waiting
        gpu_base = 16'h0050;
        gpu_burst = 12;
        cpu_op(1'b1, 16'h0120, 16'h5555);
        cpu_op(1'b1, 16'h0121, 16'h6666);
        cpuReq = 1'b1;
        cpuWE = 1'b0;
        cpuAddr = 16'h0120;
        txn = 2;
        txn_rd = 1'b1;
        req_cyc = cyc;
        idle(2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ram_we", ramWE, 0);
        chk("mid_rst_ram_addr", ramAddr, 0);
        chk("mid_rst_ram_wdata", ramWData, 0);
        chk("mid_rst_gpu_data", gpuData, 0);
        chk("mid_rst_stall", cpuStallCnt, 0);
        chk("mid_rst_full", wbufFull, 0);
        exp_q.delete();
        txn = 0;
        ack_cyc = -1;
        m_stall = '0;
        g_hold = '0;
        g_prev_valid = 1'b0;
        last_addr = '0;
        gpu_burst = 0;
        gpuRE = 1'b0;
        cpuReq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(6);
        chk("discard_0", mem[16'h0120], init_val(16'h0120));
        chk("discard_1", mem[16'h0121], init_val(16'h0121));

        // Randomised traffic against the reference model
        gpu_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cpu_op(1'($urandom_range(0, 1)), 16'h0300 + 16'($urandom_range(0, 15)),
                   16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        gpu_rand = 1'b0;
        idle(10);
        chk("final_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
